// File: rtl/seq_frac_div.sv
// Iterative restoring divider for FP mantissas: quotient = floor(a * 2^(W+EXTRA-1) / b),
// resolving BPC quotient bits per clock, with sticky, divide-by-zero and overflow flags.
module seq_frac_div #(
  parameter int W     = 24,
  parameter int EXTRA = 2,
  parameter int BPC   = 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W+EXTRA-1:0]   quotient,
  output logic                 sticky,
  output logic                 div_zero,
  output logic                 ovf
);

  localparam int QW = W + EXTRA;
  localparam int N  = QW / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((W + EXTRA) % BPC != 0) begin : g_bpc_check
    $fatal(1, "seq_frac_div: W+EXTRA must be a multiple of BPC");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [W-1:0]    b_reg;
  logic [W+1:0]    rem;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic [W+1:0]    b_ext;
  logic [W+1:0]    r_work;
  logic [W+1:0]    d_work;
  logic [W+1:0]    kept;
  logic            q_bit;
  logic [BPC-1:0]  q_step;
  logic [W+1:0]    rem_next;
  logic [QW+BPC-1:0] q_wide;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign b_ext    = {2'b00, b_reg};
  assign q_wide   = {quotient, q_step};

  // BPC unrolled restoring steps; kept holds the last step's remainder before its shift.
  always_comb begin
    r_work   = rem;
    d_work   = '0;
    kept     = '0;
    q_bit    = 1'b0;
    q_step   = '0;
    for (int i = 0; i < BPC; i++) begin
      d_work = r_work - b_ext;
      q_bit  = ~d_work[W+1];
      kept   = q_bit ? d_work : r_work;
      q_step[BPC-1-i] = q_bit;
      r_work = {kept[W:0], 1'b0};
    end
    rem_next = r_work;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      quotient  <= '0;
      sticky    <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            b_reg    <= b;
            rem      <= {2'b00, a};
            cnt      <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            sticky   <= 1'b0;
            if (b == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              div_zero  <= 1'b1;
              quotient  <= '1;
            end else if ({1'b0, a} >= {b, 1'b0}) begin
              state     <= DONE;
              out_valid <= 1'b1;
              ovf       <= 1'b1;
              sticky    <= 1'b1;
              quotient  <= '1;
            end else begin
              state     <= BUSY;
              out_valid <= 1'b0;
              quotient  <= '0;
            end
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          rem      <= rem_next;
          quotient <= q_wide[QW-1:0];
          cnt      <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sticky    <= |kept;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frac_div.sv
// Bench for seq_frac_div: directed cases on a BPC=1 instance, random normalised
// pairs on BPC=1/2/13 instances, all checked against an integer reference via a scoreboard.
module tb_seq_frac_div;

  typedef struct packed {
    logic [25:0] q;
    logic        st;
    logic        dz;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        iv [3];
  logic        ir [3];
  logic        ovl [3];
  logic        ordy [3];
  logic        st [3];
  logic        dz [3];
  logic        of [3];
  logic [23:0] av [3];
  logic [23:0] bv [3];
  logic [25:0] qo [3];

  int   errors = 0;
  int   checks = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  seq_frac_div #(.W(24), .EXTRA(2), .BPC(1)) dut_b1 (
    .clk(clk), .arst(arst), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
    .out_valid(ovl[0]), .out_ready(ordy[0]), .quotient(qo[0]), .sticky(st[0]),
    .div_zero(dz[0]), .ovf(of[0]));

  seq_frac_div #(.W(24), .EXTRA(2), .BPC(2)) dut_b2 (
    .clk(clk), .arst(arst), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
    .out_valid(ovl[1]), .out_ready(ordy[1]), .quotient(qo[1]), .sticky(st[1]),
    .div_zero(dz[1]), .ovf(of[1]));

  seq_frac_div #(.W(24), .EXTRA(2), .BPC(13)) dut_b13 (
    .clk(clk), .arst(arst), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2]), .b(bv[2]),
    .out_valid(ovl[2]), .out_ready(ordy[2]), .quotient(qo[2]), .sticky(st[2]),
    .div_zero(dz[2]), .ovf(of[2]));

  function automatic exp_t model(input logic [23:0] x, input logic [23:0] y);
    exp_t e;
    longint unsigned num;
    e = '0;
    if (y == 24'd0) begin
      e.q  = '1;
      e.dz = 1'b1;
    end else if (64'(x) >= 64'(y) * 64'd2) begin
      e.q  = '1;
      e.st = 1'b1;
      e.ov = 1'b1;
    end else begin
      num  = 64'(x) << 25;
      e.q  = 26'(num / 64'(y));
      e.st = (num % 64'(y)) != 64'd0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input int d, input string tag, input exp_t e);
    chk({tag, ".valid"}, 64'(ovl[d]), 64'd1);
    chk({tag, ".quotient"}, 64'(qo[d]), 64'(e.q));
    chk({tag, ".sticky"}, 64'(st[d]), 64'(e.st));
    chk({tag, ".div_zero"}, 64'(dz[d]), 64'(e.dz));
    chk({tag, ".ovf"}, 64'(of[d]), 64'(e.ov));
  endtask

  task automatic wait_valid(input int d, output int lat);
    lat = 0;
    while (!ovl[d] && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input int d, input logic [23:0] x, input logic [23:0] y,
                        input int exp_lat, input string tag);
    exp_t e;
    int   k;
    int   lat;
    av[d] = x;
    bv[d] = y;
    iv[d] = 1'b1;
    sb.push_back(model(x, y));
    k = 0;
    while (!ir[d] && k < 50) begin
      tick();
      k++;
    end
    chk({tag, ".ready"}, 64'(ir[d]), 64'd1);
    tick();
    iv[d] = 1'b0;
    wait_valid(d, lat);
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    e = sb.pop_front();
    check_result(d, tag, e);
    $display("op %s a=%06h b=%06h q=%07h sticky=%0d dz=%0d ovf=%0d lat=%0d",
             tag, x, y, qo[d], st[d], dz[d], of[d], lat);
    ordy[d] = 1'b1;
    tick();
    ordy[d] = 1'b0;
    chk({tag, ".retire"}, 64'(ovl[d]), 64'd0);
  endtask

  initial begin
    exp_t        e;
    int          lat;
    logic [23:0] x;
    logic [23:0] y;
    int          lats [3];
    lats[0] = 26;
    lats[1] = 13;
    lats[2] = 2;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; av[d] = '0; bv[d] = '0;
    end

    // Reset state
    #2;
    chk("reset.valid", 64'(ovl[0]), 64'd0);
    chk("reset.quotient", 64'(qo[0]), 64'd0);
    chk("reset.flags", 64'({st[0], dz[0], of[0]}), 64'd0);
    tick();
    tick();
    arst = 1'b0;
    tick();
    chk("reset.in_ready", 64'(ir[0]), 64'd1);

    // Directed cases
    run_op(0, 24'h800000, 24'h800000, 26, "one_by_one");
    run_op(0, 24'h800000, 24'hC00000, 26, "two_thirds");
    run_op(0, 24'hFFFFFF, 24'h800000, 26, "max_by_one");
    run_op(0, 24'h900000, 24'h000000, 0, "div_zero");
    run_op(0, 24'h800000, 24'h3FFFFF, 0, "overflow");
    run_op(0, 24'h000001, 24'h000003, 26, "unnormalised");

    // Backpressure, then retire and accept on the same edge
    av[0] = 24'hC00000; bv[0] = 24'h800000; iv[0] = 1'b1;
    sb.push_back(model(av[0], bv[0]));
    chk("bp.ready", 64'(ir[0]), 64'd1);
    tick();
    iv[0] = 1'b0;
    wait_valid(0, lat);
    chk("bp.latency", 64'(lat), 64'd26);
    e = sb[0];
    for (int i = 0; i < 10; i++) begin
      chk("bp.hold_valid", 64'(ovl[0]), 64'd1);
      chk("bp.hold_quotient", 64'(qo[0]), 64'(e.q));
      chk("bp.hold_in_ready", 64'(ir[0]), 64'd0);
      tick();
    end
    check_result(0, "bp.first", e);
    av[0] = 24'h900000; bv[0] = 24'hC00000; iv[0] = 1'b1; ordy[0] = 1'b1;
    #1;
    chk("bp.b2b_ready", 64'(ir[0]), 64'd1);
    sb.push_back(model(av[0], bv[0]));
    tick();
    iv[0] = 1'b0; ordy[0] = 1'b0;
    void'(sb.pop_front());
    $display("op bp.first a=c00000 b=800000 q=%07h retired with back-to-back accept", e.q);
    chk("bp.b2b_busy_valid", 64'(ovl[0]), 64'd0);
    chk("bp.b2b_busy_ready", 64'(ir[0]), 64'd0);
    wait_valid(0, lat);
    chk("bp.b2b_latency", 64'(lat), 64'd26);
    e = sb.pop_front();
    check_result(0, "bp.second", e);
    $display("op bp.second a=900000 b=c00000 q=%07h sticky=%0d lat=%0d", qo[0], st[0], lat);
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;

    // Asynchronous reset in the middle of an operation
    av[0] = 24'h800000; bv[0] = 24'h800000; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    repeat (10) tick();
    arst = 1'b1;
    #1;
    chk("arst.valid", 64'(ovl[0]), 64'd0);
    chk("arst.quotient", 64'(qo[0]), 64'd0);
    chk("arst.flags", 64'({st[0], dz[0], of[0]}), 64'd0);
    $display("op arst mid-operation: in-flight 1.0/1.0 discarded");
    tick();
    arst = 1'b0;
    tick();
    chk("arst.in_ready", 64'(ir[0]), 64'd1);
    run_op(0, 24'h800000, 24'h800000, 26, "after_arst");

    // Random normalised pairs across all three unroll factors
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < ((d == 0) ? 100 : 1000); i++) begin
        x = 24'($urandom) | 24'h800000;
        y = 24'($urandom) | 24'h800000;
        run_op(d, x, y, lats[d], $sformatf("rnd_bpc%0d", (d == 0) ? 1 : ((d == 1) ? 2 : 13)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
